// File: rtl/gpu_pkg.sv
// gpu_pkg: shared opcodes, instruction field positions, FSM states and error codes
package gpu_pkg;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LD = 4'h2, OP_ST = 4'h3;
  localparam logic [3:0] OP_VADD = 4'h4, OP_VSUB = 4'h5, OP_VMUL = 4'h6, OP_DOT = 4'h7;
  localparam logic [3:0] OP_SETTID = 4'h8, OP_INCTID = 4'h9, OP_BLT = 4'hA, OP_BRA = 4'hB;
  localparam logic [3:0] OP_VRELU = 4'hC, OP_HALT = 4'hF;
  localparam int F_OP = 28, F_RD = 25, F_RS1 = 22, F_RS2 = 19, F_BSEL = 17;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2, S_LDWB = 2'd3} state_t;
  localparam logic [1:0] ERR_NONE = 2'd0, ERR_ILLEGAL = 2'd1, ERR_WDOG = 2'd2, ERR_ABORT = 2'd3;
endpackage

// File: rtl/gpu_simd_alu.sv
// gpu_simd_alu: combinational lane-wise VADD/VSUB/VMUL/VRELU and signed DOT product
module gpu_simd_alu
  import gpu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LANE_W = 16,
  localparam int DATA_W = LANES * LANE_W
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);
  localparam int AW0 = 2 * LANE_W + $clog2(LANES);
  localparam int AW = AW0 < 32 ? 32 : AW0;
  logic [DATA_W-1:0] w_add, w_sub, w_mul, w_relu;
  logic signed [AW-1:0] w_prod [LANES];
  logic signed [AW-1:0] w_acc;
  logic signed [31:0] w_lo;
  logic signed [DATA_W-1:0] w_dot;
  logic w_unused;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [LANE_W-1:0] w_a, w_b;
    logic signed [AW-1:0] w_ax, w_bx;
    assign w_a = i_a[i*LANE_W +: LANE_W];
    assign w_b = i_b[i*LANE_W +: LANE_W];
    assign w_ax = w_a;
    assign w_bx = w_b;
    assign w_add[i*LANE_W +: LANE_W] = w_a + w_b;
    assign w_sub[i*LANE_W +: LANE_W] = w_a - w_b;
    assign w_mul[i*LANE_W +: LANE_W] = w_a * w_b;
    assign w_relu[i*LANE_W +: LANE_W] = w_a[LANE_W-1] ? '0 : w_a;
    assign w_prod[i] = w_ax * w_bx;
  end
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < LANES; k++) w_acc = w_acc + w_prod[k];
  end
  // low 32 bits of the accumulator, sign-extended to the full vector
  assign w_lo = w_acc[31:0];
  assign w_dot = w_lo;
  assign w_unused = ^w_acc;
  assign o_y = i_op == OP_VADD  ? w_add  :
               i_op == OP_VSUB  ? w_sub  :
               i_op == OP_VMUL  ? w_mul  :
               i_op == OP_VRELU ? w_relu :
               i_op == OP_DOT   ? w_dot  : '0;
endmodule

// File: rtl/gpu_core_mc.sv
// gpu_core_mc: multi-cycle FSM-sequenced SIMD GPU core with sync-read IMEM/DMEM,
// watchdog, abort and saturating cycle/instruction counters.
module gpu_core_mc
  import gpu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LANE_W = 16,
  parameter int PC_W = 8,
  parameter int DMEM_AW = 10,
  parameter int TID_W = 10,
  parameter int WDOG_W = 20,
  localparam int DATA_W = LANES * LANE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        a_base,
  input  logic [31:0]        b_base,
  input  logic [31:0]        c_base,
  input  logic [31:0]        n_words,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        inst_cnt,
  output logic [PC_W-1:0]    dbg_pc,
  output logic [31:0]        dbg_ir,
  output logic [TID_W-1:0]   dbg_tid,
  output logic [PC_W-1:0]    imem_raddr,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_re,
  output logic [DMEM_AW-1:0] dmem_raddr,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_waddr,
  output logic [DATA_W-1:0]  dmem_wdata
);
  state_t r_state, w_next;
  logic [PC_W-1:0] r_pc, w_pc_n;
  logic [TID_W-1:0] r_tid, w_tid_n;
  logic [31:0] r_ir, r_cyc, r_inst;
  logic [WDOG_W-1:0] r_wdog;
  logic r_done, r_err;
  logic [1:0] r_code, w_code;
  logic [DATA_W-1:0] r_rf [8];
  logic [31:0] w_ir, w_base, w_ea32;
  logic [3:0] w_op;
  logic [15:0] w_imm;
  logic [DATA_W-1:0] w_rs1_d, w_rs2_d, w_alu, w_rf_wd;
  logic w_rf_we, w_retire, w_launch, w_halt, w_trap, w_re, w_we, w_unused;
  // the fetched word is live during EXEC; r_ir holds it afterwards
  assign w_ir = r_state == S_EXEC ? imem_rdata : r_ir;
  assign w_op = w_ir[F_OP +: 4];
  assign w_imm = w_ir[15:0];
  assign w_rs1_d = r_rf[w_ir[F_RS1 +: 3]];
  assign w_rs2_d = r_rf[w_ir[F_RS2 +: 3]];
  assign w_base = w_ir[F_BSEL +: 2] == 2'd0 ? a_base :
                  w_ir[F_BSEL +: 2] == 2'd1 ? b_base :
                  w_ir[F_BSEL +: 2] == 2'd2 ? c_base : '0;
  assign w_ea32 = w_base + 32'(r_tid) + {{16{w_imm[15]}}, w_imm};
  assign w_unused = ^{w_ir[16], w_ea32};
  gpu_simd_alu #(.LANES(LANES), .LANE_W(LANE_W)) u_alu (
    .i_op(w_op), .i_a(w_rs1_d), .i_b(w_rs2_d), .o_y(w_alu)
  );
  always_comb begin
    w_next = r_state;
    w_pc_n = r_pc;
    w_tid_n = r_tid;
    w_rf_we = 1'b0;
    w_rf_wd = w_alu;
    w_retire = 1'b0;
    w_launch = 1'b0;
    w_halt = 1'b0;
    w_trap = 1'b0;
    w_code = ERR_NONE;
    w_re = 1'b0;
    w_we = 1'b0;
    if (r_state == S_IDLE) begin
      w_launch = start;
      w_next = start ? S_FETCH : S_IDLE;
    end else if (abort) begin
      w_next = S_IDLE;
      w_trap = 1'b1;
      w_code = ERR_ABORT;
    end else if (&r_wdog) begin
      w_next = S_IDLE;
      w_trap = 1'b1;
      w_code = ERR_WDOG;
    end else if (r_state == S_FETCH) begin
      w_next = S_EXEC;
    end else if (r_state == S_LDWB) begin
      w_next = S_FETCH;
      w_rf_we = 1'b1;
      w_rf_wd = dmem_rdata;
      w_retire = 1'b1;
    end else begin
      w_next = S_FETCH;
      w_pc_n = r_pc + 1'b1;
      w_retire = 1'b1;
      case (w_op)
        OP_NOP: ;
        OP_LDI: begin
          w_rf_we = 1'b1;
          w_rf_wd = DATA_W'(w_imm);
        end
        OP_LD: begin
          w_re = 1'b1;
          w_retire = 1'b0;
          w_next = S_LDWB;
        end
        OP_ST: w_we = 1'b1;
        OP_VADD, OP_VSUB, OP_VMUL, OP_DOT, OP_VRELU: w_rf_we = 1'b1;
        OP_SETTID: w_tid_n = w_imm[TID_W-1:0];
        OP_INCTID: w_tid_n = r_tid + 1'b1;
        OP_BLT: w_pc_n = 32'(r_tid) < n_words ? w_imm[PC_W-1:0] : r_pc + 1'b1;
        OP_BRA: w_pc_n = w_imm[PC_W-1:0];
        OP_HALT: begin
          w_pc_n = r_pc;
          w_halt = 1'b1;
          w_next = S_IDLE;
        end
        default: begin
          w_pc_n = r_pc;
          w_trap = 1'b1;
          w_code = ERR_ILLEGAL;
          w_next = S_IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
      r_tid <= '0;
      r_ir <= '0;
      r_cyc <= '0;
      r_inst <= '0;
      r_wdog <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_code <= ERR_NONE;
    end else if (w_launch) begin
      r_pc <= '0;
      r_tid <= '0;
      r_cyc <= '0;
      r_inst <= '0;
      r_wdog <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_code <= ERR_NONE;
    end else if (r_state != S_IDLE) begin
      if (r_state == S_EXEC) r_ir <= imem_rdata;
      r_pc <= w_pc_n;
      r_tid <= w_tid_n;
      r_wdog <= r_wdog + 1'b1;
      if (~&r_cyc) r_cyc <= r_cyc + 1'b1;
      if (w_retire && ~&r_inst) r_inst <= r_inst + 1'b1;
      if (w_halt) r_done <= 1'b1;
      if (w_trap) begin
        r_err <= 1'b1;
        r_code <= w_code;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_rf_we && !rst) r_rf[w_ir[F_RD +: 3]] <= w_rf_wd;
  end
  assign busy = r_state != S_IDLE;
  assign done = r_done;
  assign err = r_err;
  assign err_code = r_code;
  assign cycle_cnt = r_cyc;
  assign inst_cnt = r_inst;
  assign dbg_pc = r_pc;
  assign dbg_ir = w_ir;
  assign dbg_tid = r_tid;
  assign imem_raddr = r_pc;
  assign dmem_re = w_re & ~rst;
  assign dmem_we = w_we & ~rst;
  assign dmem_raddr = w_ea32[DMEM_AW-1:0];
  assign dmem_waddr = w_ea32[DMEM_AW-1:0];
  assign dmem_wdata = w_rs2_d;
endmodule

// File: tb/tb_gpu_core_mc.sv
// tb_gpu_core_mc: directed self-checking bench for gpu_core_mc with sync-read memory models
module tb_gpu_core_mc;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [31:0] a_base = '0, b_base = '0, c_base = '0, n_words = '0;
  logic busy, done, err, dmem_re, dmem_we;
  logic [1:0] err_code;
  logic [31:0] cycle_cnt, inst_cnt, dbg_ir, imem_rdata;
  logic [7:0] dbg_pc, imem_raddr;
  logic [9:0] dbg_tid, dmem_raddr, dmem_waddr;
  logic [63:0] dmem_rdata, dmem_wdata;
  logic [31:0] imem [256];
  logic [63:0] dmem [1024];
  logic wd_start = 1'b0, wd_busy, wd_done, wd_err, wd_re, wd_we;
  logic [1:0] wd_code;
  logic [31:0] wd_cyc, wd_inst, wd_ir;
  logic [7:0] wd_pc, wd_iaddr;
  logic [9:0] wd_tid, wd_raddr, wd_waddr;
  logic [63:0] wd_wdata;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  gpu_core_mc dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .a_base(a_base), .b_base(b_base),
    .c_base(c_base), .n_words(n_words), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .dbg_pc(dbg_pc), .dbg_ir(dbg_ir), .dbg_tid(dbg_tid),
    .imem_raddr(imem_raddr), .imem_rdata(imem_rdata), .dmem_re(dmem_re), .dmem_raddr(dmem_raddr),
    .dmem_rdata(dmem_rdata), .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata)
  );

  gpu_core_mc #(.WDOG_W(4)) u_wd (
    .clk(clk), .rst(rst), .start(wd_start), .abort(1'b0), .a_base(32'd0), .b_base(32'd0),
    .c_base(32'd0), .n_words(32'd0), .busy(wd_busy), .done(wd_done), .err(wd_err), .err_code(wd_code),
    .cycle_cnt(wd_cyc), .inst_cnt(wd_inst), .dbg_pc(wd_pc), .dbg_ir(wd_ir), .dbg_tid(wd_tid),
    .imem_raddr(wd_iaddr), .imem_rdata(32'hB000_0000), .dmem_re(wd_re), .dmem_raddr(wd_raddr),
    .dmem_rdata(64'd0), .dmem_we(wd_we), .dmem_waddr(wd_waddr), .dmem_wdata(wd_wdata)
  );

  always @(posedge clk) begin
    imem_rdata <= imem[imem_raddr];
    if (dmem_re) dmem_rdata <= dmem[dmem_raddr];
    if (dmem_we) dmem[dmem_waddr] <= dmem_wdata;
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [2:0] rd, rs1, rs2,
                                      input logic [1:0] bs, input logic [15:0] imm);
    return {op, rd, rs1, rs2, bs, 1'b0, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int max_cyc);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin errors++; $display("FAIL timeout busy=%0b after %0d cycles", busy, n); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) dmem[i] <= 64'h0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({busy, done, err, err_code, dmem_we, dmem_re} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=0", {busy, done, err, err_code, dmem_we, dmem_re});
    end
    checks++;
    if ({cycle_cnt, inst_cnt} !== 64'h0) begin
      errors++; $display("FAIL reset_counters got=%h/%h exp=0/0", cycle_cnt, inst_cnt);
    end
    checks++;
    if ({dbg_pc, dbg_tid, dbg_ir} !== 50'h0) begin
      errors++; $display("FAIL reset_dbg pc=%h tid=%h ir=%h exp=0", dbg_pc, dbg_tid, dbg_ir);
    end
  endtask

  task automatic test_basic();
    imem[0] = enc(4'h1, 3'd1, 3'd0, 3'd0, 2'd0, 16'd5);
    imem[1] = enc(4'h1, 3'd2, 3'd0, 3'd0, 2'd0, 16'd7);
    imem[2] = enc(4'h4, 3'd3, 3'd1, 3'd2, 2'd0, 16'd0);
    imem[3] = enc(4'h3, 3'd0, 3'd0, 3'd3, 2'd2, 16'd0);
    imem[4] = enc(4'hF, 3'd0, 3'd0, 3'd0, 2'd0, 16'd0);
    c_base = 32'h100;
    dmem[10'h100] <= 64'hDEAD;
    run(100);
    checks++;
    if (dmem[10'h100] !== 64'h000C) begin errors++; $display("FAIL basic_store got=%h exp=000c", dmem[10'h100]); end
    checks++;
    if ({done, err} !== 2'b10) begin errors++; $display("FAIL basic_done done=%b err=%b exp=1/0", done, err); end
    checks++;
    if (inst_cnt !== 32'd5) begin errors++; $display("FAIL basic_inst got=%0d exp=5", inst_cnt); end
    checks++;
    if (cycle_cnt !== 32'd10) begin errors++; $display("FAIL basic_cycles got=%0d exp=10", cycle_cnt); end
  endtask

  task automatic test_vector_loop();
    logic [15:0] a, b, e;
    for (int i = 0; i < 4; i++) begin
      a = 16'(i + 1);
      b = 16'(10 + i);
      dmem[i] <= {a, a, a, a};
      dmem[10'h40 + i] <= {b, b, b, b};
    end
    for (int i = 0; i < 5; i++) dmem[10'h80 + i] <= 64'hDEAD;
    a_base = 32'h0; b_base = 32'h40; c_base = 32'h80; n_words = 32'd4;
    imem[0] = enc(4'h8, 3'd0, 3'd0, 3'd0, 2'd0, 16'd0);
    imem[1] = enc(4'h2, 3'd1, 3'd0, 3'd0, 2'd0, 16'd0);
    imem[2] = enc(4'h2, 3'd2, 3'd0, 3'd0, 2'd1, 16'd0);
    imem[3] = enc(4'h4, 3'd3, 3'd1, 3'd2, 2'd0, 16'd0);
    imem[4] = enc(4'h3, 3'd0, 3'd0, 3'd3, 2'd2, 16'd0);
    imem[5] = enc(4'h9, 3'd0, 3'd0, 3'd0, 2'd0, 16'd0);
    imem[6] = enc(4'hA, 3'd0, 3'd0, 3'd0, 2'd0, 16'd1);
    imem[7] = enc(4'hF, 3'd0, 3'd0, 3'd0, 2'd0, 16'd0);
    run(500);
    for (int i = 0; i < 4; i++) begin
      e = 16'(11 + 2 * i);
      checks++;
      if (dmem[10'h80 + i] !== {e, e, e, e}) begin
        errors++; $display("FAIL loop_c%0d got=%h exp=%h", i, dmem[10'h80 + i], {e, e, e, e});
      end
    end
    checks++;
    if (dmem[10'h84] !== 64'hDEAD) begin errors++; $display("FAIL loop_c4 got=%h exp=dead", dmem[10'h84]); end
    checks++;
    if (dbg_tid !== 10'd4) begin errors++; $display("FAIL loop_tid got=%0d exp=4", dbg_tid); end
    checks++;
    if ({inst_cnt, cycle_cnt} !== {32'd26, 32'd60}) begin
      errors++; $display("FAIL loop_counts inst=%0d cyc=%0d exp=26/60", inst_cnt, cycle_cnt);
    end
  endtask

  task automatic test_alu();
    dmem[10'h10] <= 64'h0005_0004_0003_FFFE;
    dmem[10'h11] <= 64'h0003_0003_0003_0003;
    dmem[10'h12] <= 64'h0000_0000_0000_7FFF;
    dmem[10'h13] <= 64'h0001_7FFF_FFFF_8000;
    dmem[10'h100] <= 64'hDEAD;
    c_base = 32'h105;
    imem[0] = enc(4'h2, 3'd1, 3'd0, 3'd0, 2'd3, 16'h10);
    imem[1] = enc(4'h2, 3'd2, 3'd0, 3'd0, 2'd3, 16'h11);
    imem[2] = enc(4'h7, 3'd3, 3'd1, 3'd2, 2'd0, 16'h0);
    imem[3] = enc(4'h3, 3'd0, 3'd0, 3'd3, 2'd3, 16'h20);
    imem[4] = enc(4'h2, 3'd4, 3'd0, 3'd0, 2'd3, 16'h12);
    imem[5] = enc(4'h1, 3'd5, 3'd0, 3'd0, 2'd0, 16'd2);
    imem[6] = enc(4'h6, 3'd6, 3'd4, 3'd5, 2'd0, 16'h0);
    imem[7] = enc(4'h3, 3'd0, 3'd0, 3'd6, 2'd3, 16'h21);
    imem[8] = enc(4'h2, 3'd4, 3'd0, 3'd0, 2'd3, 16'h13);
    imem[9] = enc(4'hC, 3'd6, 3'd4, 3'd0, 2'd0, 16'h0);
    imem[10] = enc(4'h3, 3'd0, 3'd0, 3'd6, 2'd3, 16'h22);
    imem[11] = enc(4'h5, 3'd6, 3'd1, 3'd2, 2'd0, 16'h0);
    imem[12] = enc(4'h3, 3'd0, 3'd0, 3'd6, 2'd3, 16'h23);
    imem[13] = enc(4'h3, 3'd0, 3'd0, 3'd3, 2'd2, 16'hFFFB);
    imem[14] = enc(4'hF, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0);
    run(200);
    checks++;
    if (dmem[10'h20] !== 64'h1E) begin errors++; $display("FAIL alu_dot got=%h exp=1e", dmem[10'h20]); end
    checks++;
    if (dmem[10'h21] !== 64'hFFFE) begin errors++; $display("FAIL alu_vmul got=%h exp=fffe", dmem[10'h21]); end
    checks++;
    if (dmem[10'h22] !== 64'h0001_7FFF_0000_0000) begin
      errors++; $display("FAIL alu_vrelu got=%h exp=00017fff00000000", dmem[10'h22]);
    end
    checks++;
    if (dmem[10'h23] !== 64'h0002_0001_0000_FFFB) begin
      errors++; $display("FAIL alu_vsub got=%h exp=000200010000fffb", dmem[10'h23]);
    end
    checks++;
    if (dmem[10'h100] !== 64'h1E) begin errors++; $display("FAIL alu_neg_imm got=%h exp=1e", dmem[10'h100]); end
  endtask

  task automatic test_illegal();
    imem[0] = 32'h0; imem[1] = 32'h0; imem[2] = 32'h0;
    imem[3] = enc(4'hD, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0);
    run(100);
    checks++;
    if ({err, err_code, busy, done} !== 5'b10100) begin
      errors++; $display("FAIL illegal_flags err=%b code=%0d busy=%b done=%b exp=1/1/0/0", err, err_code, busy, done);
    end
    checks++;
    if (dbg_pc !== 8'd3) begin errors++; $display("FAIL illegal_pc got=%0d exp=3", dbg_pc); end
    imem[0] = enc(4'hF, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0);
    run(100);
    checks++;
    if ({err, err_code, done} !== 4'b0001) begin
      errors++; $display("FAIL illegal_restart err=%b code=%0d done=%b exp=0/0/1", err, err_code, done);
    end
  endtask

  task automatic test_watchdog();
    int n;
    wd_start = 1'b1;
    tick();
    wd_start = 1'b0;
    n = 1;
    while (wd_busy && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if ({wd_busy, wd_err, wd_code} !== 4'b0110) begin
      errors++; $display("FAIL wdog_flags busy=%b err=%b code=%0d exp=0/1/2", wd_busy, wd_err, wd_code);
    end
    checks++;
    if ({wd_cyc, wd_inst} !== {32'd16, 32'd7}) begin
      errors++; $display("FAIL wdog_counts cyc=%0d inst=%0d exp=16/7", wd_cyc, wd_inst);
    end
  endtask

  task automatic test_abort();
    imem[0] = enc(4'h1, 3'd1, 3'd0, 3'd0, 2'd0, 16'h55);
    imem[1] = enc(4'h3, 3'd0, 3'd0, 3'd1, 2'd3, 16'h30);
    imem[2] = enc(4'hF, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0);
    dmem[10'h30] <= 64'hDEAD;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    checks++;
    if (dmem_we !== 1'b1) begin errors++; $display("FAIL abort_st_exec dmem_we=%b exp=1", dmem_we); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, err, err_code, done} !== 5'b01110) begin
      errors++; $display("FAIL abort_flags busy=%b err=%b code=%0d done=%b exp=0/1/3/0", busy, err, err_code, done);
    end
    tick();
    checks++;
    if (dmem[10'h30] !== 64'hDEAD) begin errors++; $display("FAIL abort_no_write got=%h exp=dead", dmem[10'h30]); end
  endtask

  task automatic test_back_to_back();
    int n;
    test_basic_prog();
    dmem[10'h100] <= 64'h0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if ({busy, err} !== 2'b10) begin errors++; $display("FAIL start_over_abort busy=%b err=%b exp=1/0", busy, err); end
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if ({busy, done, err, inst_cnt, cycle_cnt} !== {3'b010, 32'd5, 32'd10}) begin
      errors++; $display("FAIL start_while_busy busy=%b done=%b err=%b inst=%0d cyc=%0d exp=0/1/0/5/10",
                         busy, done, err, inst_cnt, cycle_cnt);
    end
    checks++;
    if (dmem[10'h100] !== 64'h000C) begin errors++; $display("FAIL b2b_store got=%h exp=000c", dmem[10'h100]); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({done, err, err_code} !== 4'b1000) begin
      errors++; $display("FAIL abort_idle done=%b err=%b code=%0d exp=1/0/0", done, err, err_code);
    end
  endtask

  task automatic test_basic_prog();
    imem[0] = enc(4'h1, 3'd1, 3'd0, 3'd0, 2'd0, 16'd5);
    imem[1] = enc(4'h1, 3'd2, 3'd0, 3'd0, 2'd0, 16'd7);
    imem[2] = enc(4'h4, 3'd3, 3'd1, 3'd2, 2'd0, 16'd0);
    imem[3] = enc(4'h3, 3'd0, 3'd0, 3'd3, 2'd2, 16'd0);
    imem[4] = enc(4'hF, 3'd0, 3'd0, 3'd0, 2'd0, 16'd0);
    c_base = 32'h100;
  endtask

  task automatic test_rst_mid_ld();
    imem[0] = enc(4'h1, 3'd7, 3'd0, 3'd0, 2'd0, 16'h99);
    imem[1] = enc(4'hF, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0);
    run(100);
    imem[0] = enc(4'h2, 3'd7, 3'd0, 3'd0, 2'd3, 16'h10);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (dmem_re !== 1'b1) begin errors++; $display("FAIL ld_exec dmem_re=%b exp=1", dmem_re); end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, done, err, err_code, dmem_we, dmem_re, cycle_cnt, inst_cnt, dbg_pc, dbg_tid, dbg_ir} !== 121'h0) begin
      errors++; $display("FAIL rst_mid_ld busy=%b done=%b err=%b cyc=%0d inst=%0d pc=%0d ir=%h exp=all 0",
                         busy, done, err, cycle_cnt, inst_cnt, dbg_pc, dbg_ir);
    end
    rst = 1'b0;
    tick();
    imem[0] = enc(4'h3, 3'd0, 3'd0, 3'd7, 2'd3, 16'h32);
    dmem[10'h32] <= 64'hDEAD;
    run(100);
    checks++;
    if (dmem[10'h32] !== 64'h99) begin errors++; $display("FAIL rst_no_writeback got=%h exp=99", dmem[10'h32]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vector_loop();
    test_alu();
    test_illegal();
    test_watchdog();
    test_abort();
    test_back_to_back();
    test_rst_mid_ld();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
